// File: rtl/fpu_issue_queue_pkg.sv
// Shared FPU types: instruction word, float layout, opcode set and operand
// classes used by the issue queue and its class decoder.
package fpu_issue_queue_pkg;

  typedef enum logic [2:0] {
    FPU_ADD  = 3'd0,
    FPU_SUB  = 3'd1,
    FPU_MULT = 3'd2,
    FPU_DIV  = 3'd3,
    FPU_SQRT = 3'd4
  } fpu_op_t;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exponent;
    logic [22:0] mantissa;
  } float_t;

  typedef struct packed {
    fpu_op_t    op;
    logic [1:0] rmode;
    float_t     opa;
    float_t     opb;
  } fpu_instruction_t;

  typedef enum logic [2:0] {
    NORMAL = 3'd0,
    ZERO   = 3'd1,
    DENORM = 3'd2,
    INF    = 3'd3,
    QNAN   = 3'd4,
    SNAN   = 3'd5
  } fpu_class_t;

  // Highest defined opcode; anything above is dropped at issue.
  localparam logic [2:0] FPU_OP_MAX = 3'd4;

  function automatic logic op_legal(input logic [2:0] op);
    return op <= FPU_OP_MAX;
  endfunction

endpackage

// File: rtl/fpu_issue_queue_class_decode.sv
// fpu_class_decode: combinational single-precision operand classifier.
module fpu_class_decode
  import fpu_issue_queue_pkg::*;
(
  input  float_t     f,
  output fpu_class_t cls
);

  // Exponent all-zero / all-one selects the special encodings.
  always_comb begin
    cls = NORMAL;
    if (f.exponent == 8'h00) begin
      cls = (f.mantissa == '0) ? ZERO : DENORM;
    end else if (f.exponent == 8'hFF) begin
      if (f.mantissa == '0)      cls = INF;
      else if (f.mantissa[22])   cls = QNAN;
      else                       cls = SNAN;
    end
  end

endmodule

// File: rtl/fpu_issue_queue.sv
// fpu_issue_queue: FIFO-buffered single-issue stage in front of the FPU core.
// Optional feature macro: FPU_OPCLASS_EN (registers operand classes at issue;
// when undefined, opa_class/opb_class are tied to NORMAL).
module fpu_issue_queue
  import fpu_issue_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  fpu_instruction_t in_instr,
  input  logic             flush,
  output fpu_instruction_t iss_instr,
  output logic             iss_start,
  input  logic             core_done,
  output logic             busy,
  output logic             err_illegal,
  output logic [CNT_W-1:0] count,
  output fpu_class_t       opa_class,
  output fpu_class_t       opb_class
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]       state;
  fpu_instruction_t mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  fpu_instruction_t head;
  logic             empty, push, pop, head_legal;

  assign head       = mem[rd_ptr];
  assign empty      = (count == '0);
  // Ready depends only on registered count, so a same-cycle pop never
  // frees a slot early.
  assign in_ready   = (count != CNT_W'(DEPTH)) && !flush;
  assign push       = in_valid && in_ready;
  // core_done only matters while an op is outstanding.
  assign pop        = !empty && ((state == IDLE) || ((state == BUSY) && core_done));
  assign head_legal = op_legal(head.op);
  assign busy       = (state == BUSY);

  // Storage array, written at the tail on every accepted push.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_instr;
  end

  // Pointers and occupancy; flush wins over the normal update but the
  // head pop of the same cycle has already been consumed by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Issue FSM: pop the head when idle or when the current op completes;
  // illegal heads are dropped with an error pulse and leave the FSM idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      iss_instr   <= '0;
      iss_start   <= 1'b0;
      err_illegal <= 1'b0;
    end else begin
      iss_start   <= 1'b0;
      err_illegal <= 1'b0;
      if (pop) begin
        if (head_legal) begin
          iss_instr <= head;
          iss_start <= 1'b1;
          state     <= BUSY;
        end else begin
          err_illegal <= 1'b1;
          state       <= IDLE;
        end
      end else if (core_done) begin
        state <= IDLE;
      end
    end
  end

`ifdef FPU_OPCLASS_EN
  fpu_class_t opa_cls_d, opb_cls_d;

  fpu_class_decode u_cls_a (.f(head.opa), .cls(opa_cls_d));
  fpu_class_decode u_cls_b (.f(head.opb), .cls(opb_cls_d));

  // Capture classes together with iss_instr so they describe the issued op.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      opa_class <= NORMAL;
      opb_class <= NORMAL;
    end else if (pop && head_legal) begin
      opa_class <= opa_cls_d;
      opb_class <= opb_cls_d;
    end
  end
`else
  assign opa_class = NORMAL;
  assign opb_class = NORMAL;
`endif

endmodule

// File: tb/tb_fpu_issue_queue.sv
// Directed self-checking bench for fpu_issue_queue (DEPTH=4).
module tb_fpu_issue_queue;
  import fpu_issue_queue_pkg::*;

  logic             clk, rst_n, in_valid, in_ready, flush;
  fpu_instruction_t in_instr, iss_instr;
  logic             iss_start, core_done, busy, err_illegal;
  logic [2:0]       count;
  fpu_class_t       opa_class, opb_class;

  int errors = 0;
  int checks = 0;

`ifdef FPU_OPCLASS_EN
  localparam bit CLS_EN = 1'b1;
`else
  localparam bit CLS_EN = 1'b0;
`endif

  fpu_issue_queue #(.DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .flush(flush), .iss_instr(iss_instr),
    .iss_start(iss_start), .core_done(core_done), .busy(busy),
    .err_illegal(err_illegal), .count(count),
    .opa_class(opa_class), .opb_class(opb_class)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic fpu_instruction_t mk(input logic [2:0] op,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [68:0] v;
    v = {op, 2'b00, a, b};
    return fpu_instruction_t'(v);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic done_pulse();
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; flush = 1'b0; core_done = 1'b0;
    tick(); tick();
    checks++; if (count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", count); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b exp 1", in_ready); end
    checks++; if ({iss_start, busy, err_illegal} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b exp 000", {iss_start, busy, err_illegal}); end
    checks++; if (iss_instr !== 69'd0) begin errors++; $display("FAIL reset_iss_instr got %h exp 0", iss_instr); end
    checks++; if ({opa_class, opb_class} !== 6'd0) begin errors++; $display("FAIL reset_class got %h exp 0", {opa_class, opb_class}); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    fpu_instruction_t op;
    op = mk(3'd0, 32'h3F800000, 32'h40000000);
    in_valid = 1'b1; in_instr = op;
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd1 || iss_start !== 1'b0) begin errors++; $display("FAIL single_accept got count=%0d start=%b exp 1 0", count, iss_start); end
    tick();
    checks++; if (iss_start !== 1'b1) begin errors++; $display("FAIL single_start got %b exp 1", iss_start); end
    checks++; if (iss_instr !== op) begin errors++; $display("FAIL single_instr got %h exp %h", iss_instr, op); end
    checks++; if (busy !== 1'b1 || count !== 3'd0) begin errors++; $display("FAIL single_busy got busy=%b count=%0d exp 1 0", busy, count); end
    tick();
    checks++; if (iss_start !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL single_hold got start=%b busy=%b exp 0 1", iss_start, busy); end
    done_pulse();
    checks++; if (busy !== 1'b0 || iss_start !== 1'b0) begin errors++; $display("FAIL single_done got busy=%b start=%b exp 0 0", busy, iss_start); end
  endtask

  task automatic test_fill();
    fpu_instruction_t ops [5];
    for (int i = 0; i < 5; i++) ops[i] = mk(3'(i), 32'h1000 + i, 32'h2000 + i);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_instr = ops[i];
      tick();
    end
    checks++; if (count !== 3'd4 || in_ready !== 1'b0) begin errors++; $display("FAIL fill_full got count=%0d ready=%b exp 4 0", count, in_ready); end
    checks++; if (busy !== 1'b1 || iss_instr !== ops[0]) begin errors++; $display("FAIL fill_head got busy=%b instr=%h exp 1 %h", busy, iss_instr, ops[0]); end
    in_instr = mk(3'd1, 32'hDEADBEEF, 32'h0);
    tick();
    in_valid = 1'b0;
    checks++; if (count !== 3'd4) begin errors++; $display("FAIL fill_reject got count=%0d exp 4", count); end
    for (int k = 1; k < 5; k++) begin
      done_pulse();
      checks++; if (iss_start !== 1'b1 || iss_instr !== ops[k]) begin errors++; $display("FAIL fill_b2b%0d got start=%b instr=%h exp 1 %h", k, iss_start, iss_instr, ops[k]); end
      checks++; if (count !== 3'(4 - k)) begin errors++; $display("FAIL fill_count%0d got %0d exp %0d", k, count, 4 - k); end
    end
    done_pulse();
    checks++; if (busy !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL fill_drain got busy=%b count=%0d exp 0 0", busy, count); end
    tick();
    checks++; if (iss_start !== 1'b0) begin errors++; $display("FAIL fill_no_extra got %b exp 0", iss_start); end
  endtask

  task automatic test_illegal();
    fpu_instruction_t mul;
    mul = mk(3'd2, 32'h40400000, 32'h40800000);
    in_valid = 1'b1; in_instr = mk(3'b110, 32'h1, 32'h2);
    tick();
    in_instr = mul;
    tick();
    in_valid = 1'b0;
    checks++; if (err_illegal !== 1'b1 || iss_start !== 1'b0) begin errors++; $display("FAIL illegal_pulse got err=%b start=%b exp 1 0", err_illegal, iss_start); end
    checks++; if (busy !== 1'b0 || count !== 3'd1) begin errors++; $display("FAIL illegal_state got busy=%b count=%0d exp 0 1", busy, count); end
    tick();
    checks++; if (err_illegal !== 1'b0 || iss_start !== 1'b1) begin errors++; $display("FAIL illegal_next got err=%b start=%b exp 0 1", err_illegal, iss_start); end
    checks++; if (iss_instr !== mul) begin errors++; $display("FAIL illegal_mul got %h exp %h", iss_instr, mul); end
    done_pulse();
  endtask

  task automatic test_flush();
    fpu_instruction_t ops [4];
    for (int i = 0; i < 4; i++) ops[i] = mk(3'd1, 32'h3000 + i, 32'h4000 + i);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_instr = ops[i];
      tick();
    end
    in_valid = 1'b0;
    checks++; if (count !== 3'd3 || busy !== 1'b1) begin errors++; $display("FAIL flush_pre got count=%0d busy=%b exp 3 1", count, busy); end
    flush = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %b exp 0", in_ready); end
    tick();
    flush = 1'b0;
    checks++; if (count !== 3'd0 || busy !== 1'b1 || iss_start !== 1'b0) begin errors++; $display("FAIL flush_clear got count=%0d busy=%b start=%b exp 0 1 0", count, busy, iss_start); end
    done_pulse();
    checks++; if (busy !== 1'b0 || iss_start !== 1'b0) begin errors++; $display("FAIL flush_done got busy=%b start=%b exp 0 0", busy, iss_start); end
    tick();
    checks++; if (iss_start !== 1'b0 || count !== 3'd0) begin errors++; $display("FAIL flush_idle got start=%b count=%0d exp 0 0", iss_start, count); end
  endtask

  task automatic test_flush_pop();
    fpu_instruction_t ops [3];
    for (int i = 0; i < 3; i++) ops[i] = mk(3'd3, 32'h5000 + i, 32'h6000 + i);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = ops[i];
      tick();
    end
    in_valid = 1'b0;
    flush = 1'b1; core_done = 1'b1;
    tick();
    flush = 1'b0; core_done = 1'b0;
    checks++; if (iss_start !== 1'b1 || iss_instr !== ops[1]) begin errors++; $display("FAIL flushpop_issue got start=%b instr=%h exp 1 %h", iss_start, iss_instr, ops[1]); end
    checks++; if (count !== 3'd0 || busy !== 1'b1) begin errors++; $display("FAIL flushpop_count got count=%0d busy=%b exp 0 1", count, busy); end
    done_pulse();
  endtask

  task automatic test_classes();
    in_valid = 1'b1; in_instr = mk(3'd0, 32'h7F800000, 32'h7FC00000);
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (opa_class !== (CLS_EN ? INF : NORMAL)) begin errors++; $display("FAIL class_inf got %0d exp %0d", opa_class, CLS_EN ? 3 : 0); end
    checks++; if (opb_class !== (CLS_EN ? QNAN : NORMAL)) begin errors++; $display("FAIL class_qnan got %0d exp %0d", opb_class, CLS_EN ? 4 : 0); end
    done_pulse();
    in_valid = 1'b1; in_instr = mk(3'd2, 32'h00000001, 32'h7F800001);
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (opa_class !== (CLS_EN ? DENORM : NORMAL)) begin errors++; $display("FAIL class_denorm got %0d exp %0d", opa_class, CLS_EN ? 2 : 0); end
    checks++; if (opb_class !== (CLS_EN ? SNAN : NORMAL)) begin errors++; $display("FAIL class_snan got %0d exp %0d", opb_class, CLS_EN ? 5 : 0); end
    done_pulse();
  endtask

  task automatic test_reset_mid();
    fpu_instruction_t nop;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_instr = mk(3'd4, 32'h7000 + i, 32'h0);
      tick();
    end
    in_valid = 1'b0;
    checks++; if (busy !== 1'b1 || count !== 3'd2) begin errors++; $display("FAIL rstmid_pre got busy=%b count=%0d exp 1 2", busy, count); end
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || count !== 3'd0 || iss_instr !== 69'd0) begin errors++; $display("FAIL rstmid_async got busy=%b count=%0d instr=%h exp 0 0 0", busy, count, iss_instr); end
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (iss_start !== 1'b0 || err_illegal !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL rstmid_quiet%0d got start=%b err=%b busy=%b exp 0 0 0", i, iss_start, err_illegal, busy); end
    end
    nop = mk(3'd1, 32'hC0000000, 32'h3F000000);
    in_valid = 1'b1; in_instr = nop;
    tick();
    in_valid = 1'b0;
    tick();
    checks++; if (iss_start !== 1'b1 || iss_instr !== nop) begin errors++; $display("FAIL rstmid_new got start=%b instr=%h exp 1 %h", iss_start, iss_instr, nop); end
    done_pulse();
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_illegal();
    test_flush();
    test_flush_pop();
    test_classes();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
